// File: rtl/map_tile_renderer.sv
// map_tile_renderer: converts a screen pixel coordinate into a 12-bit RGB colour from a
// boundary wall, a writable platform tile bitmap and a frame-synchronous vertical camera.
// Two-stage pipeline: stage 1 registers wall/on flags and the bitmap read, stage 2 the colour.
// Build option: define MAP_SCROLL_EN to include the scroll registers and world-y wrap logic;
// without it world y equals screen y and the scroll/frame ports are ignored.
module map_tile_renderer #(
  parameter int unsigned MAP_WIDTH_X    = 640,
  parameter int unsigned MAP_WIDTH_Y    = 480,
  parameter int unsigned WALL_WIDTH     = 10,
  parameter int unsigned TILE_SHIFT     = 4,
  parameter int unsigned TILES_X        = 40,
  parameter int unsigned TILES_Y        = 30,
  parameter logic [11:0] WALL_COLOR     = 12'h000,
  parameter logic [11:0] FLOOR_COLOR    = 12'hf80,
  parameter logic [11:0] PLATFORM_COLOR = 12'h0a0,
  parameter logic [11:0] OFF_COLOR      = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  map_x,
  input  logic [9:0]  map_y,
  input  logic        map_on,
  input  logic        frame_start,
  input  logic        scroll_wr,
  input  logic [9:0]  scroll_y_in,
  input  logic        tile_wr_en,
  input  logic [10:0] tile_wr_addr,
  input  logic        tile_wr_data,
  output logic [11:0] rgb,
  output logic        rgb_on
);

  localparam int unsigned NumTiles = TILES_X * TILES_Y;
  localparam logic [10:0] WorldH   = 11'(TILES_Y << TILE_SHIFT);
  localparam logic [10:0] WallW    = 11'(WALL_WIDTH);
  localparam logic [10:0] RightX   = 11'(MAP_WIDTH_X - WALL_WIDTH);
  localparam logic [10:0] TopY     = 11'((TILES_Y << TILE_SHIFT) - WALL_WIDTH);
  localparam logic [10:0] TilesX   = 11'(TILES_X);
  localparam logic [10:0] TilesY   = 11'(TILES_Y);
  localparam logic [10:0] NumT     = 11'(NumTiles);

  // Map height is implied by the tile grid; kept as a parameter for interface compatibility.
  logic [9:0] unused_map_h;
  assign unused_map_h = 10'(MAP_WIDTH_Y);

  logic [10:0] wy;

`ifdef MAP_SCROLL_EN
  logic [9:0]  scroll_pend_q, scroll_act_q;
  logic [9:0]  scroll_clamped;
  logic [10:0] wy_sum;

  // Clamp requested offset and form the wrapped world y.
  always_comb begin
    scroll_clamped = scroll_y_in;
    if ({1'b0, scroll_y_in} >= WorldH) scroll_clamped = 10'(WorldH - 11'd1);
    wy_sum = {1'b0, map_y} + {1'b0, scroll_act_q};
    wy     = wy_sum;
    if (wy_sum >= WorldH) wy = wy_sum - WorldH;
  end

  // Pending offset takes writes; active offset updates only at frame start (with bypass).
  always_ff @(posedge clk) begin
    if (rst) begin
      scroll_pend_q <= '0;
      scroll_act_q  <= '0;
    end else begin
      if (scroll_wr) scroll_pend_q <= scroll_clamped;
      if (frame_start) scroll_act_q <= scroll_wr ? scroll_clamped : scroll_pend_q;
    end
  end
`else
  logic unused_scroll;
  assign unused_scroll = ^{frame_start, scroll_wr, scroll_y_in};

  // Without scrolling the world coordinate is the screen coordinate.
  always_comb begin
    wy = {1'b0, map_y};
  end
`endif

  logic [10:0] col, row, rd_addr;
  logic        in_range, wall;

  // Tile address and wall classification for the incoming pixel.
  always_comb begin
    col      = {1'b0, map_x} >> TILE_SHIFT;
    row      = wy >> TILE_SHIFT;
    in_range = (col < TilesX) && (row < TilesY);
    rd_addr  = row * TilesX + col;
    wall     = ({1'b0, map_x} < WallW) || ({1'b0, map_x} >= RightX) ||
               (wy < WallW) || (wy >= TopY);
  end

  // Tile bitmap storage; deliberately not reset so a reset does not erase the level.
  logic bitmap_q [NumTiles];

  // Single write port; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (tile_wr_en && (tile_wr_addr < NumT)) bitmap_q[tile_wr_addr] <= tile_wr_data;
  end

  logic wall_q, on_q, tile_q;

  // Stage 1: register flags and the bitmap read (read sees pre-write data on collision).
  always_ff @(posedge clk) begin
    if (rst) begin
      wall_q <= 1'b0;
      on_q   <= 1'b0;
      tile_q <= 1'b0;
    end else begin
      wall_q <= wall;
      on_q   <= map_on;
      tile_q <= in_range ? bitmap_q[rd_addr] : 1'b0;
    end
  end

  logic [11:0] rgb_q;
  logic        rgb_on_q;

  // Stage 2: colour priority off > wall > platform > floor.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q    <= OFF_COLOR;
      rgb_on_q <= 1'b0;
    end else begin
      rgb_on_q <= on_q;
      if (!on_q)       rgb_q <= OFF_COLOR;
      else if (wall_q) rgb_q <= WALL_COLOR;
      else if (tile_q) rgb_q <= PLATFORM_COLOR;
      else             rgb_q <= FLOOR_COLOR;
    end
  end

  assign rgb    = rgb_q;
  assign rgb_on = rgb_on_q;

endmodule

// File: tb/tb_map_tile_renderer.sv
// Directed bench for map_tile_renderer; expectations adapt to whether MAP_SCROLL_EN is defined.
module tb_map_tile_renderer;

`ifdef MAP_SCROLL_EN
  localparam bit ScrollEn = 1'b1;
`else
  localparam bit ScrollEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  map_x, map_y, scroll_y_in;
  logic        map_on, frame_start, scroll_wr;
  logic        tile_wr_en, tile_wr_data;
  logic [10:0] tile_wr_addr;
  logic [11:0] rgb;
  logic        rgb_on;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  map_tile_renderer dut (
    .clk          (clk),
    .rst          (rst),
    .map_x        (map_x),
    .map_y        (map_y),
    .map_on       (map_on),
    .frame_start  (frame_start),
    .scroll_wr    (scroll_wr),
    .scroll_y_in  (scroll_y_in),
    .tile_wr_en   (tile_wr_en),
    .tile_wr_addr (tile_wr_addr),
    .tile_wr_data (tile_wr_data),
    .rgb          (rgb),
    .rgb_on       (rgb_on)
  );

  task automatic chk(input string tag, input logic [11:0] exp_rgb, input logic exp_on);
    n_vec++;
    assert (rgb === exp_rgb && rgb_on === exp_on) else begin
      n_err++;
      $error("FAIL %s: rgb=%h rgb_on=%b, expected rgb=%h rgb_on=%b",
             tag, rgb, rgb_on, exp_rgb, exp_on);
    end
  endtask

  // Drive a pixel right after a negedge and check it two edges later.
  task automatic pix(input string tag, input int x, input int y, input logic on,
                     input logic [11:0] exp_rgb);
    map_x  = 10'(x);
    map_y  = 10'(y);
    map_on = on;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk(tag, exp_rgb, on);
  endtask

  task automatic wr_tile(input int addr, input logic d);
    tile_wr_en   = 1'b1;
    tile_wr_addr = 11'(addr);
    tile_wr_data = d;
    @(posedge clk);
    @(negedge clk);
    tile_wr_en   = 1'b0;
  endtask

  task automatic scroll(input int val, input logic fs);
    scroll_wr   = 1'b1;
    scroll_y_in = 10'(val);
    frame_start = fs;
    @(posedge clk);
    @(negedge clk);
    scroll_wr   = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; map_x = 10'd300; map_y = 10'd200; map_on = 1'b1;
    frame_start = 1'b0; scroll_wr = 1'b0; scroll_y_in = '0;
    tile_wr_en = 1'b0; tile_wr_addr = '0; tile_wr_data = 1'b0;

    // Reset held three cycles with map_on high.
    @(posedge clk); @(negedge clk);
    chk("reset_during", 12'hFFF, 1'b0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("reset_after1", 12'hFFF, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("reset_after2", 12'hFFF, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("reset_first_valid", 12'hf80, 1'b1);

    // Wall and floor with zero scroll.
    pix("left_wall", 5, 200, 1'b1, 12'h000);
    pix("floor", 300, 200, 1'b1, 12'hf80);
    pix("top_wall", 300, 475, 1'b1, 12'h000);
    pix("right_wall", 630, 200, 1'b1, 12'h000);
    pix("bottom_wall", 300, 9, 1'b1, 12'h000);
    pix("bottom_edge_floor", 300, 10, 1'b1, 12'hf80);
    pix("map_off", 300, 200, 1'b0, 12'hFFF);

    // Platform tile (row 3, col 5) and an ignored out-of-range write.
    wr_tile(125, 1'b1);
    pix("platform", 85, 50, 1'b1, 12'h0a0);
    wr_tile(1200, 1'b1);
    pix("oor_write_alias", 260, 70, 1'b1, 12'hf80);
    pix("oor_write_floor", 300, 200, 1'b1, 12'hf80);

    // Deferred scroll: no effect until frame_start.
    scroll(16, 1'b0);
    pix("scroll_deferred", 85, 34, 1'b1, 12'hf80);
    frame_start = 1'b1;
    @(posedge clk); @(negedge clk);
    frame_start = 1'b0;
    pix("scroll_applied", 85, 34, 1'b1, ScrollEn ? 12'h0a0 : 12'hf80);

    // Bypass write at frame_start, with wrap of world y.
    scroll(470, 1'b1);
    pix("wrap_bypass", 300, 15, 1'b1, ScrollEn ? 12'h000 : 12'hf80);
    pix("wrap_floor", 300, 200, 1'b1, 12'hf80);

    // Out-of-range offset clamps to 479: y=51 lands on world row 3.
    scroll(600, 1'b1);
    pix("clamp", 85, 51, 1'b1, 12'h0a0);

    scroll(0, 1'b1);

    // Collision: write 0 to tile 125 while a lookup reads it.
    map_x = 10'd85; map_y = 10'd50; map_on = 1'b1;
    tile_wr_en = 1'b1; tile_wr_addr = 11'd125; tile_wr_data = 1'b0;
    @(posedge clk); @(negedge clk);
    tile_wr_en = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("collision_old", 12'h0a0, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("collision_new", 12'hf80, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
